// File: rtl/team_06_trem_ctrl.sv
// rtl/team_06_trem_ctrl.sv - tremolo sequencer: sample tick, LFO step strobe, rate and click-free enable
module team_06_trem_ctrl #(
    parameter int SAMPLE_DIV = 2500,
    parameter int RATE_MIN   = 1,
    parameter int RATE_MAX   = 15,
    parameter int RATE_RST   = 4,
    parameter int DEPTH_MAX  = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       toggle_req,
    input  logic       rate_up,
    input  logic       rate_down,
    output logic       sample_tick,
    output logic       lfo_step,
    output logic       trem_en,
    output logic [3:0] rate,
    output logic [4:0] depth_mirror,
    output logic [1:0] state
);

    localparam int SW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLE_DIV - 1);
    localparam logic [3:0]    RATE_MIN_V = 4'(RATE_MIN);
    localparam logic [3:0]    RATE_MAX_V = 4'(RATE_MAX);
    localparam logic [3:0]    RATE_RST_V = 4'(RATE_RST);
    localparam logic [4:0]    DEPTH_TOP  = 5'(DEPTH_MAX);

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] samp_cnt;
    logic [3:0]    lfo_cnt;
    logic          dir_up;
    logic          rate_inc, rate_dec, rate_last, drain_exit;

    assign sample_tick = (samp_cnt == SAMP_LAST);
    assign trem_en     = (state_q == ACTIVE) || (state_q == DRAIN);
    assign state       = state_q;

    assign rate_inc   = rate_up & ~rate_down & (rate < RATE_MAX_V);
    assign rate_dec   = rate_down & ~rate_up & (rate > RATE_MIN_V);
    assign rate_last  = (lfo_cnt == rate - 4'd1);
    // A same-cycle toggle cancels the drain, so the exit (and its step suppression) only applies without one
    assign drain_exit = (state_q == DRAIN) & ~toggle_req & sample_tick & (depth_mirror == DEPTH_TOP);
    assign lfo_step   = sample_tick & trem_en & rate_last & ~drain_exit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            samp_cnt <= '0;
        end else if (sample_tick) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rate    <= RATE_RST_V;
            lfo_cnt <= 4'd0;
        end else if (rate_inc || rate_dec) begin
            rate    <= rate_inc ? rate + 4'd1 : rate - 4'd1;
            lfo_cnt <= 4'd0;
        end else if (sample_tick && trem_en) begin
            lfo_cnt <= rate_last ? 4'd0 : lfo_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            depth_mirror <= 5'd0;
            dir_up       <= 1'b1;
        end else if (lfo_step) begin
            if (dir_up) begin
                if (depth_mirror < DEPTH_TOP) begin
                    depth_mirror <= depth_mirror + 5'd1;
                end else begin
                    depth_mirror <= depth_mirror - 5'd1;
                    dir_up       <= 1'b0;
                end
            end else begin
                if (depth_mirror > 5'd0) begin
                    depth_mirror <= depth_mirror - 5'd1;
                end else begin
                    depth_mirror <= depth_mirror + 5'd1;
                    dir_up       <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= BYPASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BYPASS: if (toggle_req) state_d = ARM;
            ARM: begin
                if (toggle_req)       state_d = BYPASS;
                else if (sample_tick) state_d = ACTIVE;
            end
            ACTIVE: if (toggle_req) state_d = DRAIN;
            DRAIN: begin
                if (toggle_req)      state_d = ACTIVE;
                else if (drain_exit) state_d = BYPASS;
            end
            default: state_d = BYPASS;
        endcase
    end

endmodule

// File: doc/team_06_trem_ctrl.md
Name: team_06_trem_ctrl

Overview:
Sequencer for the tremolo effect datapath. It generates the audio sample tick and the LFO step strobe, which is the tremolo's depth-advance clock enable. It holds a user-adjustable LFO rate and owns the tremolo enable. Enable and disable requests are applied only on sample boundaries, and disable is deferred until the triangle depth reaches its peak, so bypass switching is click-free.

Parameters:
SAMPLE_DIV, 2500, clk cycles per sample tick (25 MHz / 10 kHz)
RATE_MIN, 1, minimum sample ticks per LFO step
RATE_MAX, 15, maximum sample ticks per LFO step
RATE_RST, 4, rate value loaded at reset
DEPTH_MAX, 16, triangle peak; must match the tremolo datapath

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
toggle_req  in  1  one-cycle pulse (synchronized button): request effect on/off
rate_up  in  1  one-cycle pulse: rate +1 (slower LFO)
rate_down  in  1  one-cycle pulse: rate -1 (faster LFO)
sample_tick  out  1  one-cycle pulse every SAMPLE_DIV clks
lfo_step  out  1  one-cycle pulse; advances tremolo depth by one
trem_en  out  1  tremolo enable to the datapath
rate  out  4  current rate
depth_mirror  out  5  controller copy of the datapath depth, 0..DEPTH_MAX
state  out  2  FSM state: 0 BYPASS, 1 ARM, 2 ACTIVE, 3 DRAIN

Behaviour:
- Reset (async, n_rst low):
  - samp_cnt=0, lfo_cnt=0, rate=RATE_RST, depth_mirror=0, direction=up, state=BYPASS.
  - Outputs: sample_tick=0, lfo_step=0, trem_en=0.
- Sample counter:
  - samp_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick = (samp_cnt == SAMPLE_DIV-1), decoded from the register; free-running in all states.
- Rate:
  - Register updates on the clk edge after a pulse, saturating at RATE_MIN and RATE_MAX.
  - rate_up and rate_down together: no change.
  - Any actual rate change clears lfo_cnt to 0.
  - A saturated (no-op) request leaves lfo_cnt unchanged.
- LFO counter:
  - Increments on sample_tick while trem_en=1; wraps at rate-1.
  - lfo_step = sample_tick & trem_en & (lfo_cnt == rate-1) & ~drain_exit.
  - Held (not cleared) while trem_en=0.
- Depth mirror (same triangle as the datapath):
  - On lfo_step: if up and depth<DEPTH_MAX, depth+1; at DEPTH_MAX, depth-1 and direction=down.
  - If down and depth>0, depth-1; at 0, depth+1 and direction=up.
  - Holds otherwise.
- FSM (transitions registered):
  - BYPASS: toggle_req -> ARM.
  - ARM:
    - toggle_req -> BYPASS (cancel; toggle has priority).
    - Otherwise sample_tick -> ACTIVE.
  - ACTIVE: toggle_req -> DRAIN.
  - DRAIN:
    - toggle_req -> ACTIVE (cancel).
    - Else drain_exit = sample_tick & (depth_mirror == DEPTH_MAX) -> BYPASS.
    - lfo_step is suppressed in the drain_exit cycle, so the datapath is left at peak depth.
  - trem_en = (state == ACTIVE) | (state == DRAIN), decoded from the state register; one-cycle latency from each transition edge.
- Boundary cases:
  - Toggle arriving on the same cycle as sample_tick in ARM: cancel wins.
  - Entering DRAIN with depth already at DEPTH_MAX: exit on the next sample_tick.
  - Drain worst case is 2*DEPTH_MAX*rate sample ticks.
  - Reset mid-DRAIN: immediately BYPASS with trem_en=0.
- Width rules: lfo_cnt and rate are 4 bits; samp_cnt is $clog2(SAMPLE_DIV) bits.

Test Plan:
- Reset check (SAMPLE_DIV=4 throughout): hold n_rst low, then release -> rate=4, state=0, trem_en=0; sample_tick first high on clk edge 4 after release, then every 4 clks.
- Enable: toggle_req pulse in BYPASS -> state=ARM; ACTIVE on the first sample_tick; trem_en=1 the following cycle; lfo_step every 4th sample_tick (16 clks); depth_mirror 0,1,...,16,15.
- Rate saturation: 12 rate_up pulses -> rate=15; then rate_up+rate_down together -> rate stays 15; 20 rate_down pulses -> rate=1, after which lfo_step fires on every sample_tick.
- Deferred disable: toggle at depth_mirror=10, direction up -> state=DRAIN until depth=16 and sample_tick; no lfo_step in the exit cycle; then state=BYPASS, trem_en=0, depth_mirror=16.
- Cancels: toggle in ARM on the sample_tick cycle -> BYPASS, trem_en never asserts; toggle in DRAIN -> ACTIVE, depth continues unchanged.
- Async reset mid-DRAIN: assert n_rst between clk edges -> trem_en=0 and state=BYPASS immediately, depth_mirror=0, rate=4.
